// File: rtl/flag_pkg.sv
// Shared types and constants for the ZCSO flag update sequencer and branch condition evaluation.
package flag_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_ALU,
        ST_COMMIT
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_ALL,
        CLS_ZCS,
        CLS_ZS
    } op_class_t;

    localparam logic [4:0] NOP_CODE = 5'b11111;

    localparam int Z_BIT = 0;
    localparam int C_BIT = 1;
    localparam int S_BIT = 2;
    localparam int O_BIT = 3;

    localparam logic [3:0] COND_ALWAYS = 4'd0;
    localparam logic [3:0] COND_Z      = 4'd1;
    localparam logic [3:0] COND_NZ     = 4'd2;
    localparam logic [3:0] COND_C      = 4'd3;
    localparam logic [3:0] COND_NC     = 4'd4;
    localparam logic [3:0] COND_S      = 4'd5;
    localparam logic [3:0] COND_NS     = 4'd6;
    localparam logic [3:0] COND_O      = 4'd7;
    localparam logic [3:0] COND_NO     = 4'd8;
    localparam logic [3:0] COND_LT     = 4'd9;
    localparam logic [3:0] COND_GE     = 4'd10;
    localparam logic [3:0] COND_LE     = 4'd11;
    localparam logic [3:0] COND_GT     = 4'd12;

    function automatic op_class_t op_class(input logic [4:0] code);
        if (code inside {5'd0, 5'd1, 5'd3, 5'd4, 5'd5, 5'd6})
            return CLS_ALL;
        else if (code inside {5'd8, 5'd9})
            return CLS_ZCS;
        else if (code inside {5'd17, 5'd18, [5'd20:5'd30]})
            return CLS_ZS;
        else
            return CLS_NONE;
    endfunction

endpackage

// File: rtl/flag_cond_eval.sv
// Combinational branch condition evaluation against the ZCSO flags.
module flag_cond_eval
    import flag_pkg::*;
(
    input  logic [3:0] zcso,
    input  logic [3:0] br_cond,
    output logic       taken
);

    logic z, c, s, o;

    assign z = zcso[Z_BIT];
    assign c = zcso[C_BIT];
    assign s = zcso[S_BIT];
    assign o = zcso[O_BIT];

    always_comb begin
        taken = 1'b0;
        case (br_cond)
            COND_ALWAYS: taken = 1'b1;
            COND_Z:      taken = z;
            COND_NZ:     taken = !z;
            COND_C:      taken = c;
            COND_NC:     taken = !c;
            COND_S:      taken = s;
            COND_NS:     taken = !s;
            COND_O:      taken = o;
            COND_NO:     taken = !o;
            COND_LT:     taken = s ^ o;
            COND_GE:     taken = !(s ^ o);
            COND_LE:     taken = z | (s ^ o);
            COND_GT:     taken = !(z | (s ^ o));
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_update_seq.sv
// Sequences ALU flag-register updates and holds off branch condition reads while an update is in flight.
module flag_update_seq #(
    parameter int         TIMEOUT  = 16,
    parameter logic [4:0] NOP_CODE = flag_pkg::NOP_CODE
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       op_valid,
    input  logic [4:0] op_code,
    output logic       op_ready,
    input  logic       alu_done,
    output logic [4:0] re_ctrl,
    input  logic [3:0] zcso,
    input  logic       br_valid,
    input  logic [3:0] br_cond,
    output logic       br_ready,
    output logic       br_resp_valid,
    output logic       br_taken,
    output logic       busy,
    output logic       err_timeout
);

    import flag_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [4:0]       op_latched;
    logic [CNT_W-1:0] cnt;
    logic             op_accept;
    logic             br_accept;
    logic             cond_taken;

    assign op_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign br_ready  = !busy;
    assign re_ctrl   = (state == ST_COMMIT) ? op_latched : NOP_CODE;
    assign op_accept = op_valid && op_ready;
    assign br_accept = br_valid && br_ready;

    flag_cond_eval u_cond (
        .zcso    (zcso),
        .br_cond (br_cond),
        .taken   (cond_taken)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            op_latched    <= NOP_CODE;
            cnt           <= '0;
            err_timeout   <= 1'b0;
            br_resp_valid <= 1'b0;
            br_taken      <= 1'b0;
        end else begin
            err_timeout   <= 1'b0;
            // Branch response uses the flags present at the accept edge
            br_resp_valid <= br_accept;
            br_taken      <= br_accept && cond_taken;
            case (state)
                ST_IDLE: begin
                    if (op_accept && op_class(op_code) != CLS_NONE) begin
                        op_latched <= op_code;
                        cnt        <= '0;
                        state      <= ST_WAIT_ALU;
                    end
                end
                ST_WAIT_ALU: begin
                    // A completion on the final allowed cycle beats the timeout
                    if (alu_done) begin
                        state <= ST_COMMIT;
                    end else if (cnt == CNT_LAST) begin
                        err_timeout <= 1'b1;
                        op_latched  <= NOP_CODE;
                        state       <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_COMMIT: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flag_update_seq.sv
// Directed bench for flag_update_seq: vector table plus timeout and reset sequences.
module tb_flag_update_seq;

    logic       clock = 1'b0;
    logic       reset;
    logic       op_valid;
    logic [4:0] op_code;
    logic       op_ready;
    logic       alu_done;
    logic [4:0] re_ctrl;
    logic [3:0] zcso;
    logic       br_valid;
    logic [3:0] br_cond;
    logic       br_ready;
    logic       br_resp_valid;
    logic       br_taken;
    logic       busy;
    logic       err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    flag_update_seq #(.TIMEOUT(16), .NOP_CODE(5'b11111)) dut (
        .clock         (clock),
        .reset         (reset),
        .op_valid      (op_valid),
        .op_code       (op_code),
        .op_ready      (op_ready),
        .alu_done      (alu_done),
        .re_ctrl       (re_ctrl),
        .zcso          (zcso),
        .br_valid      (br_valid),
        .br_cond       (br_cond),
        .br_ready      (br_ready),
        .br_resp_valid (br_resp_valid),
        .br_taken      (br_taken),
        .busy          (busy),
        .err_timeout   (err_timeout)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       op_valid;
        logic [4:0] op_code;
        logic       alu_done;
        logic [3:0] zcso;
        logic       br_valid;
        logic [3:0] br_cond;
        logic       e_op_ready;
        logic [4:0] e_re_ctrl;
        logic       e_busy;
        logic       e_br_ready;
        logic       e_resp;
        logic       e_taken;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ov, input logic [4:0] oc, input logic ad,
                                input logic [3:0] z, input logic bv, input logic [3:0] bc,
                                input logic eor, input logic [4:0] ere, input logic eb,
                                input logic ebr, input logic erv, input logic et, input logic ee);
        vec_t v;
        v.op_valid = ov; v.op_code = oc; v.alu_done = ad; v.zcso = z;
        v.br_valid = bv; v.br_cond = bc;
        v.e_op_ready = eor; v.e_re_ctrl = ere; v.e_busy = eb; v.e_br_ready = ebr;
        v.e_resp = erv; v.e_taken = et; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic eor, input logic [4:0] ere,
                           input logic eb, input logic ebr, input logic erv,
                           input logic et, input logic ee);
        chk({tag, ".op_ready"},      int'(op_ready),      int'(eor));
        chk({tag, ".re_ctrl"},       int'(re_ctrl),       int'(ere));
        chk({tag, ".busy"},          int'(busy),          int'(eb));
        chk({tag, ".br_ready"},      int'(br_ready),      int'(ebr));
        chk({tag, ".br_resp_valid"}, int'(br_resp_valid), int'(erv));
        chk({tag, ".br_taken"},      int'(br_taken),      int'(et));
        chk({tag, ".err_timeout"},   int'(err_timeout),   int'(ee));
    endtask

    task automatic idle_inputs();
        op_valid = 1'b0; op_code = 5'd0; alu_done = 1'b0;
        br_valid = 1'b0; br_cond = 4'd0;
    endtask

    initial begin
        reset = 1'b1;
        zcso  = 4'd0;
        idle_inputs();

        // ops:       ov  oc      ad  zcso     bv  bc      | opr re      busy brr rv tk err
        vecs.push_back(mk(1, 5'h03, 0, 4'b0000, 0, 4'd0,  0, 5'h1F, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 5'h03, 0, 4'b0000, 0, 4'd0,  0, 5'h1F, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 5'h03, 0, 4'b0000, 0, 4'd0,  0, 5'h1F, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 5'h00, 1, 4'b0000, 0, 4'd0,  0, 5'h03, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 5'h00, 0, 4'b0000, 0, 4'd0,  1, 5'h1F, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 5'h00, 0, 4'b0001, 1, 4'd1,  1, 5'h1F, 0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 5'h00, 0, 4'b0001, 1, 4'd2,  1, 5'h1F, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 5'h00, 0, 4'b0001, 0, 4'd0,  1, 5'h1F, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 5'h02, 0, 4'b0000, 0, 4'd0,  1, 5'h1F, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 5'h00, 1, 4'b0000, 0, 4'd0,  1, 5'h1F, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 5'h08, 0, 4'b0010, 1, 4'd3,  0, 5'h1F, 1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 5'h00, 0, 4'b0010, 1, 4'd3,  0, 5'h1F, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 5'h00, 1, 4'b0010, 1, 4'd3,  0, 5'h08, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 5'h00, 0, 4'b0000, 1, 4'd3,  1, 5'h1F, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 5'h00, 0, 4'b0000, 1, 4'd3,  1, 5'h1F, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 5'h00, 0, 4'b0000, 1, 4'd4,  1, 5'h1F, 0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 5'h00, 0, 4'b1000, 1, 4'd9,  1, 5'h1F, 0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 5'h00, 0, 4'b0000, 1, 4'd11, 1, 5'h1F, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 5'h00, 0, 4'b0000, 1, 4'd12, 1, 5'h1F, 0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 5'h00, 0, 4'b1111, 1, 4'd13, 1, 5'h1F, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 5'h00, 0, 4'b0000, 1, 4'd0,  1, 5'h1F, 0, 1, 1, 1, 0));
        vecs.push_back(mk(0, 5'h00, 0, 4'b0001, 1, 4'd10, 1, 5'h1F, 0, 1, 1, 1, 0));
        vecs.push_back(mk(1, 5'h14, 1, 4'b0000, 0, 4'd0,  0, 5'h1F, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 5'h00, 1, 4'b0000, 0, 4'd0,  0, 5'h14, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 5'h00, 0, 4'b0000, 0, 4'd0,  1, 5'h1F, 0, 1, 0, 0, 0));

        tick();
        tick();
        chk_all("reset", 1, 5'h1F, 0, 1, 0, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            op_valid = vecs[i].op_valid; op_code = vecs[i].op_code;
            alu_done = vecs[i].alu_done; zcso    = vecs[i].zcso;
            br_valid = vecs[i].br_valid; br_cond = vecs[i].br_cond;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].e_op_ready, vecs[i].e_re_ctrl,
                    vecs[i].e_busy, vecs[i].e_br_ready, vecs[i].e_resp,
                    vecs[i].e_taken, vecs[i].e_err);
        end
        idle_inputs();
        zcso = 4'd0;

        // Timeout: no alu_done, abort on the 16th edge after accept
        op_valid = 1'b1; op_code = 5'h00;
        tick();
        op_valid = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i < 16)
                chk_all($sformatf("tmo%0d", i), 0, 5'h1F, 1, 0, 0, 0, 0);
            else
                chk_all("tmo_abort", 1, 5'h1F, 0, 1, 0, 0, 1);
        end
        tick();
        chk_all("tmo_after", 1, 5'h1F, 0, 1, 0, 0, 0);

        // alu_done on the final allowed cycle still commits
        op_valid = 1'b1; op_code = 5'h05;
        tick();
        op_valid = 1'b0;
        for (int i = 1; i <= 15; i++) tick();
        chk_all("win_wait", 0, 5'h1F, 1, 0, 0, 0, 0);
        alu_done = 1'b1;
        tick();
        chk_all("win_commit", 0, 5'h05, 1, 0, 0, 0, 0);
        alu_done = 1'b0;
        tick();
        chk_all("win_idle", 1, 5'h1F, 0, 1, 0, 0, 0);

        // Reset in WAIT_ALU, then a late alu_done must not commit
        op_valid = 1'b1; op_code = 5'h01;
        tick();
        op_valid = 1'b0;
        tick();
        chk_all("rst_pre", 0, 5'h1F, 1, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk_all("rst_async", 1, 5'h1F, 0, 1, 0, 0, 0);
        tick();
        reset = 1'b0;
        alu_done = 1'b1;
        tick();
        chk_all("rst_done_ignored", 1, 5'h1F, 0, 1, 0, 0, 0);
        alu_done = 1'b0;
        tick();
        chk_all("rst_no_commit", 1, 5'h1F, 0, 1, 0, 0, 0);
        zcso = 4'b0100; br_valid = 1'b1; br_cond = 4'd9;
        tick();
        chk_all("rst_br_lt_s", 1, 5'h1F, 0, 1, 1, 1, 0);
        zcso = 4'b1100;
        tick();
        chk_all("rst_br_lt_so", 1, 5'h1F, 0, 1, 1, 0, 0);
        br_valid = 1'b0;
        tick();
        chk_all("rst_br_end", 1, 5'h1F, 0, 1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
